// File: rtl/apb_ucpd_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : apb_ucpd_tx_sched
// Description : UCPD transmit scheduler. Arbitrates hard-reset and message
//               requests, enforces the interframe gap after TX/RX activity,
//               discards messages while the line is busy, aborts a message
//               for a hard reset, and runs a per-frame bit-tick watchdog.
//               Every output is registered; status outputs are 1-cycle pulses.
// Ports       : ic_clk/ic_rst_n  clock, async active-low reset
//               ucpden           enable; low flushes everything to IDLE
//               txsend/txhrst    level requests, held until their *_clr pulse
//               rx_busy          receive frame on line
//               ifrgap           interframe gap in half-bit ticks
//               hbit_clk_red/bit_clk_red  half-bit / bit tick pulses
//               tx_eop_cmplt     core EOP sent pulse
//               transmit_en/tx_hrst  frame enables to the core
//               txsend_clr/txhrst_clr/tx_msgsent/tx_hrstsent/tx_msg_disc/
//               tx_tmo           status pulses
//               busy             scheduler not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module apb_ucpd_tx_sched #(
  parameter int GAP_W    = 5,
  parameter int TMO_W    = 12,
  parameter int TMO_BITS = 3000
) (
  input  logic             ic_clk,
  input  logic             ic_rst_n,
  input  logic             ucpden,
  input  logic             txsend,
  input  logic             txhrst,
  input  logic             rx_busy,
  input  logic [GAP_W-1:0] ifrgap,
  input  logic             hbit_clk_red,
  input  logic             bit_clk_red,
  input  logic             tx_eop_cmplt,
  output logic             transmit_en,
  output logic             tx_hrst,
  output logic             txsend_clr,
  output logic             txhrst_clr,
  output logic             tx_msgsent,
  output logic             tx_hrstsent,
  output logic             tx_msg_disc,
  output logic             tx_tmo,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GAP     = 3'd1,
    ST_TX_MSG  = 3'd2,
    ST_TX_HRST = 3'd3,
    ST_ABORT   = 3'd4
  } state_t;

  localparam logic [GAP_W-1:0] c_GAP_ONE  = GAP_W'(1);
  localparam logic [TMO_W-1:0] c_TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TMO_BITS - 1);

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               rx_busy_q;
  logic               transmit_en_q, tx_hrst_q;
  logic               txsend_clr_q, txsend_clr_d;
  logic               txhrst_clr_q, txhrst_clr_d;
  logic               msgsent_q, msgsent_d;
  logic               hrstsent_q, hrstsent_d;
  logic               disc_q, disc_d;
  logic               tmo_q, tmo_d;
  logic               busy_q;

  logic               w_req_send, w_req_hrst, w_rx_fall, w_launch_ok;
  logic               w_tmo_hit, w_load_gap;

  // A request is ignored in the cycle its clear pulse is out, because the
  // register block only drops the level one cycle after seeing the clear.
  assign w_req_send  = txsend & ~txsend_clr_q;
  assign w_req_hrst  = txhrst & ~txhrst_clr_q;
  assign w_rx_fall   = rx_busy_q & ~rx_busy;
  // The falling-edge cycle itself reloads the gap, so it can never launch.
  assign w_launch_ok = (gap_cnt_q == '0) & ~rx_busy & ~w_rx_fall;
  assign w_tmo_hit   = bit_clk_red & (tmo_cnt_q == c_TMO_LAST);

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    txsend_clr_d = 1'b0;
    txhrst_clr_d = 1'b0;
    msgsent_d    = 1'b0;
    hrstsent_d   = 1'b0;
    disc_d       = 1'b0;
    tmo_d        = 1'b0;
    w_load_gap   = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAP: begin
        tmo_cnt_d = '0;
        if (state_q == ST_GAP && !w_launch_ok) begin
          state_d = ST_GAP;
        end else if (w_req_hrst && w_launch_ok) begin
          state_d = ST_TX_HRST;
        end else if (w_req_send && rx_busy) begin
          disc_d       = 1'b1;
          txsend_clr_d = 1'b1;
          state_d      = w_req_hrst ? ST_GAP : ST_IDLE;
        end else if (w_req_send && w_launch_ok) begin
          state_d = ST_TX_MSG;
        end else if (w_req_send || w_req_hrst) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_TX_MSG, ST_TX_HRST: begin
        if (bit_clk_red) tmo_cnt_d = tmo_cnt_q + c_TMO_ONE;
        // Completion outranks both the watchdog and a late hard-reset request.
        if (tx_eop_cmplt) begin
          w_load_gap = 1'b1;
          state_d    = (ifrgap != '0) ? ST_GAP : ST_IDLE;
          if (state_q == ST_TX_MSG) begin
            msgsent_d    = 1'b1;
            txsend_clr_d = 1'b1;
          end else begin
            hrstsent_d   = 1'b1;
            txhrst_clr_d = 1'b1;
          end
        end else if (w_tmo_hit) begin
          w_load_gap   = 1'b1;
          tmo_d        = 1'b1;
          state_d      = ST_GAP;
          txsend_clr_d = (state_q == ST_TX_MSG);
          txhrst_clr_d = (state_q == ST_TX_HRST);
        end else if (state_q == ST_TX_MSG && w_req_hrst) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        tmo_cnt_d    = '0;
        disc_d       = 1'b1;
        txsend_clr_d = 1'b1;
        w_load_gap   = 1'b1;
        state_d      = ST_GAP;
      end
      default: begin
        tmo_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase

    if (state_d != ST_TX_MSG && state_d != ST_TX_HRST) tmo_cnt_d = '0;

    if (w_load_gap || w_rx_fall) begin
      gap_cnt_d = ifrgap;
    end else if (hbit_clk_red && gap_cnt_q != '0) begin
      gap_cnt_d = gap_cnt_q - c_GAP_ONE;
    end else begin
      gap_cnt_d = gap_cnt_q;
    end

    if (!ucpden) begin
      state_d      = ST_IDLE;
      gap_cnt_d    = '0;
      tmo_cnt_d    = '0;
      txsend_clr_d = 1'b0;
      txhrst_clr_d = 1'b0;
      msgsent_d    = 1'b0;
      hrstsent_d   = 1'b0;
      disc_d       = 1'b0;
      tmo_d        = 1'b0;
    end
  end

  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      state_q       <= ST_IDLE;
      gap_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      rx_busy_q     <= 1'b0;
      transmit_en_q <= 1'b0;
      tx_hrst_q     <= 1'b0;
      txsend_clr_q  <= 1'b0;
      txhrst_clr_q  <= 1'b0;
      msgsent_q     <= 1'b0;
      hrstsent_q    <= 1'b0;
      disc_q        <= 1'b0;
      tmo_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rx_busy_q     <= rx_busy & ucpden;
      transmit_en_q <= (state_d == ST_TX_MSG) || (state_d == ST_TX_HRST);
      tx_hrst_q     <= (state_d == ST_TX_HRST);
      txsend_clr_q  <= txsend_clr_d;
      txhrst_clr_q  <= txhrst_clr_d;
      msgsent_q     <= msgsent_d;
      hrstsent_q    <= hrstsent_d;
      disc_q        <= disc_d;
      tmo_q         <= tmo_d;
      busy_q        <= (state_d != ST_IDLE);
    end
  end

  assign transmit_en = transmit_en_q;
  assign tx_hrst     = tx_hrst_q;
  assign txsend_clr  = txsend_clr_q;
  assign txhrst_clr  = txhrst_clr_q;
  assign tx_msgsent  = msgsent_q;
  assign tx_hrstsent = hrstsent_q;
  assign tx_msg_disc = disc_q;
  assign tx_tmo      = tmo_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire
